// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter: state/owner codes, default timeout
// and the latched memory command record.
package bus_arb_pkg;

    // State codes double as the owner field driven to the outside world.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_LSU   = 2'b10;

    localparam logic [1:0] OWN_NONE  = ST_IDLE;
    localparam logic [1:0] OWN_FETCH = ST_FETCH;
    localparam logic [1:0] OWN_LSU   = ST_LSU;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } bus_cmd_t;

endpackage

// File: rtl/bus_arb_if.sv
// Requester and memory-side signals of the bus arbiter, bundled for port use.
interface bus_arb_if;

    logic        f_req;
    logic [15:0] f_addr;
    logic [31:0] f_data;
    logic        f_ack;

    logic        l_req;
    logic        l_we;
    logic [15:0] l_addr;
    logic [7:0]  l_wdata;
    logic [7:0]  l_rdata;
    logic        l_ack;

    logic        m_req;
    logic        m_we;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata;
    logic [31:0] m_rdata;
    logic        m_rdy;

    logic        err;
    logic [1:0]  owner;

    // Arbiter side.
    modport master (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata, m_rdy,
        output f_data, f_ack, l_rdata, l_ack, m_req, m_we, m_addr, m_wdata,
        output err, owner
    );

    // Requester/memory side.
    modport slave (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, m_rdata, m_rdy,
        input  f_data, f_ack, l_rdata, l_ack, m_req, m_we, m_addr, m_wdata,
        input  err, owner
    );

endinterface

// File: rtl/bus_arb_rr2.sv
// Two-way round-robin pick: when both request, grant the one not served last.
module rr2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,   // 0: req0 served last, 1: req1 served last
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = '0;
        if (req0_i && req1_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/bus_arb.sv
// Fetch / load-store arbiter onto a single memory port with round-robin
// grant, latched command, wait counter and timeout abort.
module bus_arb
    import bus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    bus_arb_if.master bus
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  wcnt_q, wcnt_d;
    bus_cmd_t    cmd_q, cmd_d;
    logic [31:0] fdata_q, fdata_d;
    logic [7:0]  ldata_q, ldata_d;
    logic        fack_q, fack_d;
    logic        lack_q, lack_d;
    logic        err_q, err_d;

    logic        f_elig;
    logic        l_elig;
    logic [1:0]  gnt;

    // A requester is not eligible in its own ack cycle.
    assign f_elig = bus.f_req & ~fack_q;
    assign l_elig = bus.l_req & ~lack_q;

    rr2 u_rr2 (
        .req0_i (f_elig),
        .req1_i (l_elig),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wcnt_d  = wcnt_q;
        cmd_d   = cmd_q;
        fdata_d = fdata_q;
        ldata_d = ldata_q;
        fack_d  = 1'b0;
        lack_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (gnt[0]) begin
                    state_d    = ST_FETCH;
                    last_d     = 1'b0;
                    wcnt_d     = '0;
                    cmd_d.addr = bus.f_addr;
                    cmd_d.we   = 1'b0;
                end else if (gnt[1]) begin
                    state_d     = ST_LSU;
                    last_d      = 1'b1;
                    wcnt_d      = '0;
                    cmd_d.addr  = bus.l_addr;
                    cmd_d.we    = bus.l_we;
                    cmd_d.wdata = bus.l_wdata;
                end
            end

            ST_FETCH, ST_LSU: begin
                if (bus.m_rdy) begin
                    state_d = ST_IDLE;
                    if (state_q == ST_FETCH) begin
                        fack_d  = 1'b1;
                        fdata_d = bus.m_rdata;
                    end else begin
                        lack_d = 1'b1;
                        if (!cmd_q.we) begin
                            ldata_d = bus.m_rdata[7:0];
                        end
                    end
                end else if (wcnt_q == TMO) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    if (state_q == ST_FETCH) begin
                        fack_d  = 1'b1;
                        fdata_d = '1;
                    end else begin
                        lack_d  = 1'b1;
                        ldata_d = '1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b0;
            wcnt_q  <= '0;
            cmd_q   <= '0;
            fdata_q <= '0;
            ldata_q <= '0;
            fack_q  <= 1'b0;
            lack_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
            cmd_q   <= cmd_d;
            fdata_q <= fdata_d;
            ldata_q <= ldata_d;
            fack_q  <= fack_d;
            lack_q  <= lack_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_req   = (state_q != ST_IDLE);
    assign bus.m_we    = cmd_q.we & (state_q == ST_LSU);
    assign bus.m_addr  = cmd_q.addr;
    assign bus.m_wdata = cmd_q.wdata;
    assign bus.f_data  = fdata_q;
    assign bus.f_ack   = fack_q;
    assign bus.l_rdata = ldata_q;
    assign bus.l_ack   = lack_q;
    assign bus.err     = err_q;
    assign bus.owner   = state_q;

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: number of cycles to wait for m_rdy before a grant is aborted (legal range 1..255).
REQ-002 SHALL have the following ports, one per line:
  clk  in  1  single clock; all state changes on the rising edge
  rst  in  1  synchronous, active-high reset
  f_req  in  1  fetch request (read-only requester, from pc/ir)
  f_addr  in  16  fetch address
  f_data  out  32  fetch read data, valid while f_ack=1
  f_ack  out  1  one-cycle completion pulse to fetch
  l_req  in  1  load/store request
  l_we  in  1  1=store, 0=load
  l_addr  in  16  load/store address
  l_wdata  in  8  store data
  l_rdata  out  8  load data, valid while l_ack=1
  l_ack  out  1  one-cycle completion pulse to load/store
  m_req  out  1  memory request
  m_we  out  1  memory write enable
  m_addr  out  16  memory address
  m_wdata  out  8  memory write data
  m_rdata  in  32  memory read data
  m_rdy  in  1  memory completion, sampled only while m_req=1
  err  out  1  one-cycle timeout pulse
  owner  out  2  current grant: 00 none, 01 fetch, 10 load/store

Function
REQ-003 SHALL implement three states: IDLE, FETCH, LSU.
REQ-004 IDLE: on a clock edge with exactly one eligible request, SHALL enter that requester's state.
REQ-005 IDLE: on a clock edge with both requests eligible, SHALL grant the requester not served last (round-robin). The last-served pointer SHALL update on every grant.
REQ-006 At the grant edge, SHALL latch address, l_we and l_wdata. From the next cycle, m_req=1 and m_addr/m_we/m_wdata SHALL be driven from the latched values. m_we=0 SHALL hold in FETCH.
REQ-007 A request SHALL be ineligible in any cycle in which that requester's own ack is high. Requesters deassert req or present a new request after ack.
REQ-008 On an edge in FETCH/LSU with m_rdy=1, SHALL:
  - return to IDLE;
  - pulse the owner's ack for exactly one cycle;
  - register read data: f_data=m_rdata, or l_rdata=m_rdata[7:0] for loads;
  - leave l_rdata unchanged on stores.
REQ-009 m_req SHALL be 0 in IDLE. Every transaction therefore has at least one idle bubble between it and the next.
REQ-010 Minimum latency SHALL be 3 cycles from req sample edge to ack: grant edge, then an m_rdy=1 edge in the following cycle, then the ack cycle.
REQ-011 SHALL run an 8-bit wait counter. It clears on grant and increments on each FETCH/LSU edge with m_rdy=0.
REQ-012 When the wait counter equals TIMEOUT on an edge with m_rdy=0, SHALL:
  - return to IDLE;
  - pulse err and the owner's ack together;
  - drive data all-ones (f_data=32'hFFFFFFFF or l_rdata=8'hFF).
REQ-013 m_rdy=1 on the timeout edge SHALL count as normal completion: no err.
REQ-014 m_rdy while in IDLE SHALL be ignored.
REQ-015 Request or address changes during an active grant SHALL have no effect on m_addr/m_we/m_wdata.
REQ-016 owner SHALL reflect the current state: 00 IDLE, 01 FETCH, 10 LSU.

Reset
REQ-017 While rst=1 at an edge, SHALL:
  - enter IDLE;
  - set the last-served pointer to fetch (so load/store wins the first conflict);
  - clear the wait counter;
  - drive m_req, m_we, f_ack, l_ack, err = 0, owner = 00;
  - drive m_addr, m_wdata, f_data, l_rdata = 0.
REQ-018 Reset during FETCH/LSU SHALL abort the transaction with no ack and no err.

Structure
REQ-019 State encodings, owner codes and the default TIMEOUT SHALL live in a shared include file, arb/arb_defs.v, also used by db for owner decoding.
REQ-020 The round-robin pick SHALL be a sub-module, rr2: inputs two requests and the last-served bit; outputs a one-hot grant.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
  - Lone fetch: reset, then f_req=1, f_addr=16'h0100, m_rdy high the cycle after m_req rises, m_rdata=32'hDEADBEEF -> m_addr=16'h0100, m_we=0, f_ack one cycle, f_data=32'hDEADBEEF, owner 01 then 00.
  - Simultaneous requests after reset: f_req=1 and l_req=1 at the same edge -> LSU granted first, fetch granted after a one-cycle IDLE bubble, two acks in that order.
  - Store: l_we=1, l_addr=16'h2000, l_wdata=8'h5A -> m_we=1, m_wdata=8'h5A held until m_rdy, l_ack pulse, l_rdata unchanged.
  - Timeout: TIMEOUT=4, l_req load, m_rdy held 0 -> abort edge, err and l_ack high together, l_rdata=8'hFF, owner 00.
  - Mid-transaction reset: rst asserted during FETCH before m_rdy -> next cycle m_req=0, owner=00, no f_ack.
  - Address stability: f_addr changed from 16'h0100 to 16'h0200 during FETCH -> m_addr stays 16'h0100 until ack.
